// File: rtl/lut_extract_pkg.sv
// Shared definitions for the LUT table extractor: FSM states, default
// geometry and a counter-width helper.
package lut_extract_pkg;

   localparam int DEF_IN_W   = 8;
   localparam int DEF_OUT_W  = 1;
   localparam int DEF_WORD_W = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      WAIT  = 2'd2,
      EMIT  = 2'd3
   } state_e;

   // Width needed to count 0..n-1, never less than one bit.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/lut_lat_pipe.sv
// Delay line that carries the capture-valid flag and slot index alongside
// the neuron latency, so each response lands in the slot that produced it.
module lut_lat_pipe #(
   parameter int LAT    = 0,
   parameter int SLOT_W = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [SLOT_W-1:0] in_slot,
   output logic              out_valid,
   output logic [SLOT_W-1:0] out_slot
);

   if (LAT == 0) begin : gen_bypass
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst_n;
      assign out_valid      = in_valid;
      assign out_slot       = in_slot;
   end else begin : gen_pipe
      logic [LAT-1:0]             vld_q, vld_d;
      logic [LAT-1:0][SLOT_W-1:0] slot_q, slot_d;

      always_comb begin
         vld_d     = '0;
         slot_d    = '0;
         vld_d[0]  = in_valid;
         slot_d[0] = in_slot;
         for (int i = 1; i < LAT; i++) begin
            vld_d[i]  = vld_q[i-1];
            slot_d[i] = slot_q[i-1];
         end
      end

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            vld_q  <= '0;
            slot_q <= '0;
         end else begin
            vld_q  <= vld_d;
            slot_q <= slot_d;
         end
      end

      assign out_valid = vld_q[LAT-1];
      assign out_slot  = slot_q[LAT-1];
   end

endmodule

// File: rtl/lut_table_extractor.sv
// Sweeps every input code of a neuron, packs its responses into words and
// streams the complete truth table out over a valid/ready interface.
module lut_table_extractor
   import lut_extract_pkg::*;
#(
   parameter int IN_W       = DEF_IN_W,
   parameter int OUT_W      = DEF_OUT_W,
   parameter int WORD_W     = DEF_WORD_W,
   parameter int NEURON_LAT = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic [IN_W-1:0]   lut_in,
   input  logic [OUT_W-1:0]  lut_out,
   output logic [WORD_W-1:0] m_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              m_last
);

   localparam int E       = WORD_W / OUT_W;
   localparam int N_WORDS = ((1 << IN_W) * OUT_W) / WORD_W;
   localparam int SLOT_W  = cnt_w(E);
   localparam int WCNT_W  = cnt_w(N_WORDS);

   // Stream handshake: a word moves on any cycle with m_valid && m_ready;
   // m_data/m_last are held unchanged while m_valid is high and m_ready low.

   state_e              state_q, state_d;
   logic [IN_W-1:0]     idx_q, idx_d;
   logic [IN_W-1:0]     lut_in_q, lut_in_d;
   logic [IN_W-1:0]     idx_rev;
   logic [SLOT_W-1:0]   slot_q, slot_d;
   logic [WCNT_W-1:0]   word_q, word_d;
   logic [WORD_W-1:0]   data_q, data_d;
   logic                done_q, done_d;
   logic                sweep_act;
   logic                cap_valid;
   logic [SLOT_W-1:0]   cap_slot;
   logic                last_slot;
   logic                last_word;

   assign sweep_act = (state_q == SWEEP);
   assign last_slot = (slot_q == SLOT_W'(E - 1));
   assign last_word = (word_q == WCNT_W'(N_WORDS - 1));

   lut_lat_pipe #(
      .LAT    (NEURON_LAT),
      .SLOT_W (SLOT_W)
   ) u_lat_pipe (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (sweep_act),
      .in_slot   (slot_q),
      .out_valid (cap_valid),
      .out_slot  (cap_slot)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      slot_d  = slot_q;
      word_d  = word_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = SWEEP;
               idx_d   = '0;
               slot_d  = '0;
               word_d  = '0;
            end
         end
         SWEEP: begin
            idx_d  = idx_q + 1'b1;
            slot_d = slot_q + 1'b1;
            if (last_slot) begin
               slot_d  = '0;
               state_d = (NEURON_LAT == 0) ? EMIT : WAIT;
            end
         end
         WAIT: begin
            if (cap_valid && (cap_slot == SLOT_W'(E - 1))) begin
               state_d = EMIT;
            end
         end
         EMIT: begin
            if (m_ready) begin
               if (last_word) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  state_d = SWEEP;
                  word_d  = word_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // lut_in is registered: load the bit-reversed next index whenever the next
   // cycle is a sweep cycle, otherwise hold the last code driven.
   always_comb begin
      idx_rev = '0;
      for (int k = 0; k < IN_W; k++) begin
         idx_rev[IN_W-1-k] = idx_d[k];
      end
      lut_in_d = (state_d == SWEEP) ? idx_rev : lut_in_q;
   end

   always_comb begin
      data_d = data_q;
      for (int j = 0; j < E; j++) begin
         if (cap_valid && (cap_slot == SLOT_W'(j))) begin
            data_d[j*OUT_W +: OUT_W] = lut_out;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         slot_q   <= '0;
         word_q   <= '0;
         lut_in_q <= '0;
         data_q   <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         slot_q   <= slot_d;
         word_q   <= word_d;
         lut_in_q <= lut_in_d;
         data_q   <= data_d;
         done_q   <= done_d;
      end
   end

   assign busy    = (state_q != IDLE);
   assign done    = done_q;
   assign lut_in  = lut_in_q;
   assign m_valid = (state_q == EMIT);
   assign m_last  = m_valid && last_word;
   assign m_data  = data_q;

endmodule

// File: tb/tb_lut_table_extractor.sv
// Directed bench: two extractors (zero-latency and two-stage neuron) driven
// from a scenario table plus a hand-written mid-sweep reset sequence.
module tb_lut_table_extractor;

   logic        clk;
   logic        rst_n;
   logic        start_drv;
   logic        ready_drv;
   int          cur;
   logic        func_sel;

   logic        start0, start1;
   logic        busy0, busy1, done0, done1;
   logic [7:0]  lut_in0, lut_in1;
   logic        lut_out0, lut_out1;
   logic [31:0] m_data0, m_data1;
   logic        m_valid0, m_valid1, m_last0, m_last1;
   logic        s1_q, s2_q;

   logic        cur_busy, cur_done, cur_valid, cur_last;
   logic [31:0] cur_data;
   logic [7:0]  cur_lut_in;

   int n_err;
   int n_checks;
   logic [31:0] exp_q[$];

   typedef struct {
      int          dut;
      logic        func;
      int          stall_word;
      int          stall_len;
      int          extra_start;
      int          abort_word;
      logic [31:0] lo;
      logic [31:0] hi;
      int          per_word;
   } scen_t;

   scen_t scen[6];

   assign start0 = start_drv && (cur == 0);
   assign start1 = start_drv && (cur == 1);

   // Neuron models: combinational for dut0, two registered stages for dut1.
   assign lut_out0 = func_sel ? lut_in0[0] : lut_in0[7];
   always @(posedge clk) begin
      s1_q <= lut_in1[7];
      s2_q <= s1_q;
   end
   assign lut_out1 = s2_q;

   assign cur_busy   = (cur == 0) ? busy0    : busy1;
   assign cur_done   = (cur == 0) ? done0    : done1;
   assign cur_valid  = (cur == 0) ? m_valid0 : m_valid1;
   assign cur_last   = (cur == 0) ? m_last0  : m_last1;
   assign cur_data   = (cur == 0) ? m_data0  : m_data1;
   assign cur_lut_in = (cur == 0) ? lut_in0  : lut_in1;

   lut_table_extractor #(.NEURON_LAT(0)) dut0 (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start0),
      .busy    (busy0),
      .done    (done0),
      .lut_in  (lut_in0),
      .lut_out (lut_out0),
      .m_data  (m_data0),
      .m_valid (m_valid0),
      .m_ready (ready_drv),
      .m_last  (m_last0)
   );

   lut_table_extractor #(.NEURON_LAT(2)) dut1 (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start1),
      .busy    (busy1),
      .done    (done1),
      .lut_in  (lut_in1),
      .lut_out (lut_out1),
      .m_data  (m_data1),
      .m_valid (m_valid1),
      .m_ready (ready_drv),
      .m_last  (m_last1)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic run_scen(input scen_t s);
      int          words;
      int          dones;
      int          since;
      int          stall_n;
      int          abort_wait;
      int          post_done;
      logic [31:0] snap_d;
      logic        snap_l;
      logic [31:0] e;
      exp_q.delete();
      for (int w = 0; w < 8; w++) exp_q.push_back((w < 4) ? s.lo : s.hi);
      cur        = s.dut;
      func_sel   = s.func;
      ready_drv  = 1'b1;
      words      = 0;
      dones      = 0;
      since      = 0;
      stall_n    = 0;
      abort_wait = 0;
      post_done  = 0;
      snap_d     = '0;
      snap_l     = 1'b0;
      start_drv  = 1'b1;
      for (int k = 1; k <= 1500; k++) begin
         @(negedge clk);
         since++;
         start_drv = (s.extra_start > 0) && (k == s.extra_start);
         if (cur_done) begin
            dones++;
            check("busy_low_at_done", cur_busy, 0);
            check("done_after_last_word", words, 8);
         end
         ready_drv = 1'b1;
         if (cur_valid) begin
            if (words == s.stall_word && stall_n < s.stall_len) begin
               if (stall_n == 0) begin
                  snap_d = cur_data;
                  snap_l = cur_last;
               end else begin
                  check("stall_data_stable", cur_data, snap_d);
                  check("stall_last_stable", cur_last, snap_l);
               end
               stall_n++;
               ready_drv = 1'b0;
            end else begin
               if (exp_q.size() > 0) e = exp_q.pop_front();
               else e = 32'hDEAD_BEEF;
               check("word_data", cur_data, e);
               check("word_last", cur_last, (words == 7));
               if (words != s.stall_word) check("word_latency", since, s.per_word);
               since = 0;
               words++;
            end
         end
         if (s.abort_word >= 0 && words == s.abort_word) begin
            abort_wait++;
            if (abort_wait == 10) break;
         end
         if (dones > 0) begin
            post_done++;
            if (post_done == 40) break;
         end
      end
      start_drv = 1'b0;
      ready_drv = 1'b1;
      if (s.abort_word < 0) begin
         check("total_words", words, 8);
         check("done_pulses", dones, 1);
         check("exp_queue_empty", exp_q.size(), 0);
         check("lut_in_hold", cur_lut_in, 8'hFF);
      end
   endtask

   task automatic reset_checks();
      int valids;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("rst_busy", busy0, 0);
      check("rst_done", done0, 0);
      check("rst_m_valid", m_valid0, 0);
      check("rst_m_last", m_last0, 0);
      check("rst_m_data", m_data0, 0);
      check("rst_lut_in", lut_in0, 0);
      valids = 0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (m_valid0 || busy0) valids++;
      end
      check("no_partial_word_after_reset", valids, 0);
   endtask

   initial begin
      n_err     = 0;
      n_checks  = 0;
      start_drv = 1'b0;
      ready_drv = 1'b1;
      cur       = 0;
      func_sel  = 1'b0;
      rst_n     = 1'b0;

      //         dut func stall_w len extra abort lo             hi             per_word
      scen[0] = '{0, 1'b0, -1, 0,  0, -1, 32'hAAAAAAAA, 32'hAAAAAAAA, 33};
      scen[1] = '{0, 1'b1, -1, 0,  0, -1, 32'h00000000, 32'hFFFFFFFF, 33};
      scen[2] = '{1, 1'b0, -1, 0,  0, -1, 32'hAAAAAAAA, 32'hAAAAAAAA, 35};
      scen[3] = '{0, 1'b0,  3, 10, 0, -1, 32'hAAAAAAAA, 32'hAAAAAAAA, 33};
      scen[4] = '{0, 1'b0, -1, 0,  0,  2, 32'hAAAAAAAA, 32'hAAAAAAAA, 33};
      scen[5] = '{0, 1'b1, -1, 0, 50, -1, 32'h00000000, 32'hFFFFFFFF, 33};

      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("init_busy0", busy0, 0);
      check("init_m_valid0", m_valid0, 0);
      check("init_m_data0", m_data0, 0);
      check("init_lut_in0", lut_in0, 0);
      check("init_busy1", busy1, 0);
      check("init_m_last1", m_last1, 0);
      check("init_done1", done1, 0);

      for (int i = 0; i < 6; i++) begin
         run_scen(scen[i]);
         if (scen[i].abort_word >= 0) reset_checks();
         repeat (3) @(negedge clk);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
